sram_access_ctrl: RTL and testbench

Multi-cycle sequencer between the MEM stage and a 16-bit-wide external SRAM. Each 32-bit load or store is split into two half-word SRAM accesses, low half first. While an access is in flight, the block holds the pipeline with `ready` low; load data is returned on `data_out` in the cycle `ready` rises. It replaces the single-cycle memory instance in the MEM stage when the design targets board SRAM.

---
 rtl/sram_access_ctrl_if.sv | 29 ++
 rtl/sram_access_ctrl.sv | 110 +++++++++++
 tb/tb_sram_access_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_access_ctrl_if.sv
// Bundle between the MEM stage, the SRAM sequencer and the 16-bit board SRAM pins.
// The slave modport is the sequencer; the master modport is its environment.
interface sram_access_ctrl_if #(
  parameter int ADDR_WIDTH = 18
);
  localparam int LEN_REGISTER = 32;

  logic                    mem_read_in;
  logic                    mem_write_in;
  logic [LEN_REGISTER-1:0] address_in;
  logic [LEN_REGISTER-1:0] data_in;
  logic [LEN_REGISTER-1:0] data_out;
  logic                    ready;
  logic [ADDR_WIDTH-1:0]   sram_addr;
  logic [15:0]             sram_wdata;
  logic [15:0]             sram_rdata;
  logic                    sram_dq_oe;
  logic                    sram_we_n;

  modport master (
    output mem_read_in, mem_write_in, address_in, data_in, sram_rdata,
    input  data_out, ready, sram_addr, sram_wdata, sram_dq_oe, sram_we_n
  );

  modport slave (
    input  mem_read_in, mem_write_in, address_in, data_in, sram_rdata,
    output data_out, ready, sram_addr, sram_wdata, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_access_ctrl.sv
// Splits each 32-bit MEM-stage load/store into two half-word SRAM accesses (low half first),
// holding the pipeline with ready low until the access completes.
module sram_access_ctrl #(
  parameter int ADDR_WIDTH    = 18,
  parameter int ACCESS_CYCLES = 2
) (
  input logic              clk,
  input logic              rst,
  sram_access_ctrl_if.slave bus
);

  localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t                state;
  logic [3:0]            count;
  logic                  is_write;
  logic [ADDR_WIDTH-2:0] word_addr;
  logic [31:0]           data_q;
  logic [31:0]           read_buf;
  logic [31:0]           data_out_q;
  logic [ADDR_WIDTH-1:0] sram_addr_q;
  logic [15:0]           sram_wdata_q;
  logic                  sram_dq_oe_q;
  logic                  sram_we_n_q;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{bus.address_in[31:ADDR_WIDTH+1], bus.address_in[1:0]};

  assign bus.ready      = (state == IDLE) ? ~(bus.mem_read_in | bus.mem_write_in) : (state == DONE);
  assign bus.data_out   = data_out_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_wdata = sram_wdata_q;
  assign bus.sram_dq_oe = sram_dq_oe_q;
  assign bus.sram_we_n  = sram_we_n_q;

  // Pin outputs are set on the edge that enters each phase, so they are stable for the whole phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      count        <= 4'd0;
      is_write     <= 1'b0;
      word_addr    <= '0;
      data_q       <= 32'd0;
      read_buf     <= 32'd0;
      data_out_q   <= 32'd0;
      sram_addr_q  <= '0;
      sram_wdata_q <= 16'd0;
      sram_dq_oe_q <= 1'b0;
      sram_we_n_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.mem_read_in || bus.mem_write_in) begin
            is_write    <= bus.mem_write_in;
            word_addr   <= bus.address_in[ADDR_WIDTH:2];
            data_q      <= bus.data_in;
            count       <= 4'd0;
            sram_addr_q <= {bus.address_in[ADDR_WIDTH:2], 1'b0};
            if (bus.mem_write_in) begin
              sram_wdata_q <= bus.data_in[15:0];
              sram_dq_oe_q <= 1'b1;
              sram_we_n_q  <= 1'b0;
            end
            state <= LOW;
          end
        end
        LOW: begin
          if (count == LAST) begin
            count       <= 4'd0;
            sram_addr_q <= {word_addr, 1'b1};
            if (is_write) begin
              sram_wdata_q <= data_q[31:16];
            end else begin
              read_buf[15:0] <= bus.sram_rdata;
            end
            state <= HIGH;
          end else begin
            count <= count + 4'd1;
          end
        end
        HIGH: begin
          if (count == LAST) begin
            count        <= 4'd0;
            sram_wdata_q <= 16'd0;
            sram_dq_oe_q <= 1'b0;
            sram_we_n_q  <= 1'b1;
            // Loads publish the whole word at once; stores leave data_out untouched.
            if (!is_write) begin
              read_buf[31:16] <= bus.sram_rdata;
              data_out_q      <= {bus.sram_rdata, read_buf[15:0]};
            end
            state <= DONE;
          end else begin
            count <= count + 4'd1;
          end
        end
        DONE: begin
          count <= 4'd0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: an A=2 instance and an A=1 instance, each against a half-word SRAM
// array, checked every cycle by a transaction-timeline model plus directed literal expectations.
module tb_sram_access_ctrl;

  logic clk;
  logic rst;
  logic check_en;
  logic preload;
  int   checks;
  int   passed;

  sram_access_ctrl_if #(.ADDR_WIDTH(18)) bus0 ();
  sram_access_ctrl_if #(.ADDR_WIDTH(18)) bus1 ();

  sram_access_ctrl #(.ADDR_WIDTH(18), .ACCESS_CYCLES(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  sram_access_ctrl #(.ADDR_WIDTH(18), .ACCESS_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Board SRAM stand-ins: written on a clock edge while we_n is low, read asynchronously.
  logic [15:0] sram0 [0:1023];
  logic [15:0] sram1 [0:1023];

  always @(posedge clk) begin
    if (preload) begin
      sram1[0] <= 16'h1234;
      sram1[1] <= 16'hABCD;
    end else if (!bus1.sram_we_n) begin
      sram1[bus1.sram_addr[9:0]] <= bus1.sram_wdata;
    end
    if (!bus0.sram_we_n) sram0[bus0.sram_addr[9:0]] <= bus0.sram_wdata;
  end

  assign bus0.sram_rdata = sram0[bus0.sram_addr[9:0]];
  assign bus1.sram_rdata = sram1[bus1.sram_addr[9:0]];

  logic        rd_v [2];
  logic        wr_v [2];
  logic [31:0] ai_v [2];
  logic [31:0] di_v [2];
  logic        ready_v [2];
  logic        we_n_v [2];
  logic        oe_v [2];
  logic [17:0] addr_v [2];
  logic [15:0] wd_v [2];
  logic [31:0] do_v [2];

  assign rd_v[0] = bus0.mem_read_in;   assign rd_v[1] = bus1.mem_read_in;
  assign wr_v[0] = bus0.mem_write_in;  assign wr_v[1] = bus1.mem_write_in;
  assign ai_v[0] = bus0.address_in;    assign ai_v[1] = bus1.address_in;
  assign di_v[0] = bus0.data_in;       assign di_v[1] = bus1.data_in;
  assign ready_v[0] = bus0.ready;      assign ready_v[1] = bus1.ready;
  assign we_n_v[0] = bus0.sram_we_n;   assign we_n_v[1] = bus1.sram_we_n;
  assign oe_v[0] = bus0.sram_dq_oe;    assign oe_v[1] = bus1.sram_dq_oe;
  assign addr_v[0] = bus0.sram_addr;   assign addr_v[1] = bus1.sram_addr;
  assign wd_v[0] = bus0.sram_wdata;    assign wd_v[1] = bus1.sram_wdata;
  assign do_v[0] = bus0.data_out;      assign do_v[1] = bus1.data_out;

  // Model: mk is the cycle offset inside the current access (-1 when idle), word memory is exp_mem.
  int          mk [2];
  logic        mw [2];
  logic [16:0] mword [2];
  logic [31:0] mdata [2];
  logic [31:0] mdout [2];
  logic [17:0] mlast [2];
  logic [31:0] exp_mem [int];

  function automatic int acyc(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic [31:0] lookup(input int i, input logic [16:0] w);
    int key;
    key = i * (1 << 20) + int'(w);
    return exp_mem.exists(key) ? exp_mem[key] : 32'h0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        mk[i]    <= -1;
        mdout[i] <= 32'h0;
        mlast[i] <= 18'h0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (mk[i] < 0) begin
          if (rd_v[i] || wr_v[i]) begin
            mw[i]    <= wr_v[i];
            mword[i] <= ai_v[i][18:2];
            mdata[i] <= di_v[i];
            mk[i]    <= 1;
          end
        end else if (mk[i] == 2 * acyc(i) + 1) begin
          mk[i]    <= -1;
          mlast[i] <= {mword[i], 1'b1};
          if (mw[i]) exp_mem[i * (1 << 20) + int'(mword[i])] = mdata[i];
          else       mdout[i] <= lookup(i, mword[i]);
        end else begin
          mk[i] <= mk[i] + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h, want %h (t=%0t)", name, actual, expected, $time);
    else
      passed++;
  endtask

  always @(negedge clk) begin : compare
    int          a;
    int          k;
    logic        hi;
    logic        e_ready;
    logic        e_we_n;
    logic        e_oe;
    logic [17:0] e_addr;
    logic [15:0] e_wd;
    logic [31:0] e_do;
    if (check_en) begin
      for (int i = 0; i < 2; i++) begin
        a       = acyc(i);
        k       = mk[i];
        e_ready = !(rd_v[i] || wr_v[i]);
        e_we_n  = 1'b1;
        e_oe    = 1'b0;
        e_wd    = 16'h0;
        e_addr  = mlast[i];
        e_do    = mdout[i];
        if (k >= 1 && k <= 2 * a) begin
          hi      = (k > a);
          e_ready = 1'b0;
          e_addr  = {mword[i], hi};
          if (mw[i]) begin
            e_we_n = 1'b0;
            e_oe   = 1'b1;
            e_wd   = hi ? mdata[i][31:16] : mdata[i][15:0];
          end
        end else if (k == 2 * a + 1) begin
          e_ready = 1'b1;
          e_addr  = {mword[i], 1'b1};
          if (!mw[i]) e_do = lookup(i, mword[i]);
        end
        checkOutput($sformatf("i%0d_ready", i), 32'(ready_v[i]), 32'(e_ready));
        checkOutput($sformatf("i%0d_we_n", i), 32'(we_n_v[i]), 32'(e_we_n));
        checkOutput($sformatf("i%0d_dq_oe", i), 32'(oe_v[i]), 32'(e_oe));
        checkOutput($sformatf("i%0d_sram_addr", i), 32'(addr_v[i]), 32'(e_addr));
        checkOutput($sformatf("i%0d_sram_wdata", i), 32'(wd_v[i]), 32'(e_wd));
        checkOutput($sformatf("i%0d_data_out", i), do_v[i], e_do);
      end
    end
  end

  task automatic applyStimulus(input int i, input logic rd, input logic wr, input logic [31:0] a,
                               input logic [31:0] d);
    if (i == 0) begin
      bus0.mem_read_in = rd; bus0.mem_write_in = wr; bus0.address_in = a; bus0.data_in = d;
    end else begin
      bus1.mem_read_in = rd; bus1.mem_write_in = wr; bus1.address_in = a; bus1.data_in = d;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    passed   = 0;
    check_en = 1'b0;
    preload  = 1'b1;
    rst      = 1'b0;
    exp_mem[(1 << 20) + 0] = 32'hABCD1234;
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    checkOutput("rst_ready", 32'(bus0.ready), 32'h1);
    checkOutput("rst_we_n", 32'(bus0.sram_we_n), 32'h1);
    checkOutput("rst_data_out", bus0.data_out, 32'h0);
    checkOutput("rst_dq_oe", 32'(bus0.sram_dq_oe), 32'h0);
    checkOutput("rst_sram_addr", 32'(bus0.sram_addr), 32'h0);
    preload  = 1'b0;
    rst      = 1'b1;
    check_en = 1'b1;

    $display("[TB] A=2 write 0xDEADBEEF to 0x104");
    tick();
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0104, 32'hDEADBEEF);
    #1 checkOutput("w_c0_ready", 32'(bus0.ready), 32'h0);
    tick();
    checkOutput("w_c1_addr", 32'(bus0.sram_addr), 32'h82);
    checkOutput("w_c1_wdata", 32'(bus0.sram_wdata), 32'hBEEF);
    checkOutput("w_c1_we_n", 32'(bus0.sram_we_n), 32'h0);
    tick();
    tick();
    checkOutput("w_c3_addr", 32'(bus0.sram_addr), 32'h83);
    checkOutput("w_c3_wdata", 32'(bus0.sram_wdata), 32'hDEAD);
    checkOutput("w_c3_we_n", 32'(bus0.sram_we_n), 32'h0);
    tick();
    checkOutput("w_c4_ready", 32'(bus0.ready), 32'h0);
    tick();
    checkOutput("w_c5_ready", 32'(bus0.ready), 32'h1);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);

    $display("[TB] A=2 read back 0x104");
    tick();
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0104, 32'h0);
    repeat (5) tick();
    checkOutput("r_c5_ready", 32'(bus0.ready), 32'h1);
    checkOutput("r_c5_data", bus0.data_out, 32'hDEADBEEF);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);

    $display("[TB] read+write together, dropped in cycle 2");
    tick();
    applyStimulus(0, 1'b1, 1'b1, 32'h0000_0200, 32'h55AA33CC);
    tick();
    tick();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    checkOutput("rw_c4_ready", 32'(bus0.ready), 32'h0);
    tick();
    checkOutput("rw_c5_ready", 32'(bus0.ready), 32'h1);
    checkOutput("rw_c5_data", bus0.data_out, 32'hDEADBEEF);

    $display("[TB] reset pulse in cycle 3 of a write");
    tick();
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0300, 32'h11112222);
    repeat (3) tick();
    checkOutput("pr_c3_we_n", 32'(bus0.sram_we_n), 32'h0);
    #1 rst = 1'b0;
    #1;
    checkOutput("pr_we_n_async", 32'(bus0.sram_we_n), 32'h1);
    checkOutput("pr_dq_oe_async", 32'(bus0.sram_dq_oe), 32'h0);
    checkOutput("pr_data_out", bus0.data_out, 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    tick();
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0104, 32'h0);
    tick();
    checkOutput("pr_fresh_c1_addr", 32'(bus0.sram_addr), 32'h82);
    repeat (4) tick();
    checkOutput("pr_fresh_c5_ready", 32'(bus0.ready), 32'h1);
    checkOutput("pr_fresh_c5_data", bus0.data_out, 32'hDEADBEEF);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);

    $display("[TB] A=1 back-to-back read 0x0 then write 0x8");
    tick();
    applyStimulus(1, 1'b1, 1'b0, 32'h0, 32'h0);
    repeat (3) tick();
    checkOutput("b2b_c3_ready", 32'(bus1.ready), 32'h1);
    checkOutput("b2b_c3_data", bus1.data_out, 32'hABCD1234);
    applyStimulus(1, 1'b0, 1'b1, 32'h0000_0008, 32'hCAFEF00D);
    tick();
    checkOutput("b2b_c4_ready", 32'(bus1.ready), 32'h0);
    tick();
    checkOutput("b2b_c5_addr", 32'(bus1.sram_addr), 32'h4);
    checkOutput("b2b_c5_wdata", 32'(bus1.sram_wdata), 32'hF00D);
    tick();
    checkOutput("b2b_c6_addr", 32'(bus1.sram_addr), 32'h5);
    checkOutput("b2b_c6_wdata", 32'(bus1.sram_wdata), 32'hCAFE);
    tick();
    checkOutput("b2b_c7_ready", 32'(bus1.ready), 32'h1);
    checkOutput("b2b_c7_data", bus1.data_out, 32'hABCD1234);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0008, 32'h0);
    repeat (3) tick();
    checkOutput("b2b_rd_data", bus1.data_out, 32'hCAFEF00D);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);

    tick();
    tick();
    check_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
